seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
Parametrised, registered successor to the team's 8-bit combinational ALU.
- Adds a valid/ready handshake on both operand input and result output.
- Adds a multi-cycle shift-add multiplier and an overflow flag.
- Sits between the datapath register file and the writeback stage; accepts one operation at a time.

Parameters:
WIDTH, 8, operand/result width in bits (>=4)
CNT_W, $clog2(WIDTH+1), multiplier iteration counter width (derived, not overridden)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operands/opcode valid
in_ready  out  1  block can accept an operation
a  in  WIDTH  operand A
b  in  WIDTH  operand B
op  in  3  opcode
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  result (low half for MUL)
result_hi  out  WIDTH  upper half of MUL product, 0 otherwise
carry  out  1  carry/borrow/shift-out/product-overflow
zero  out  1  result (and result_hi) all zero
ovf  out  1  signed overflow (ADD/SUB only, else 0)

Behaviour:
- One clock (clk); reset is synchronous and active-low (rst_n).
- Reset, sampled when rst_n=0 at a clk edge:
  - state=IDLE, in_ready=1.
  - out_valid=0; result, result_hi, carry, zero, ovf all 0.
  - Reset mid-operation aborts the operation and discards any pending result.
- Opcodes:
  - 000 ADD: {carry,result}=a+b.
  - 001 SUB: {carry,result}=a-b; carry=1 means borrow (a<b unsigned).
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SHL: result=a<<1, carry=a[WIDTH-1].
  - 110 SHR: result=a>>1 logical, carry=a[0].
  - 111 MUL: unsigned a*b (see Optional Feature).
- ovf for ADD/SUB uses two's-complement sign rule on a, b, result. carry=0 for AND/OR/XOR.
- FSM states:
  - IDLE: in_ready=1. A handshake (in_valid&in_ready) latches a, b, op. Next state is EXEC, or MUL for op=111 when enabled.
  - EXEC: computes and registers the result in one cycle; next state RESP.
  - MUL: shift-add, one bit of b per cycle, LSB first. Counter runs 0..WIDTH-1; after WIDTH cycles go to RESP.
  - RESP: out_valid=1; outputs held stable until out_ready=1. The handshake cycle returns to IDLE.
- in_ready=1 only in IDLE; no acceptance in other states. No input pipelining.
- Latency from the input handshake edge to out_valid high:
  - non-MUL: 2 cycles.
  - MUL: WIDTH+1 cycles.
- Operands captured at handshake; later changes on a/b/op are ignored until the next IDLE.
- MUL outputs:
  - {result_hi,result} = full 2*WIDTH product.
  - carry = |result_hi; zero = (product==0).
- out_ready held high in RESP: the result is consumed in the first RESP cycle. in_ready rises the following cycle; there is no back-to-back bypass.
- out_valid stays high while out_ready=0, indefinitely.

Optional Feature:
Macro SEQ_ALU_MUL_EN.
- Defined: op 111 runs the MUL path as above. Counter, partial-product and multiplicand registers are present.
- Undefined:
  - MUL hardware is removed; op 111 goes through EXEC with 2-cycle latency.
  - result=0, result_hi=0, carry=0, ovf=0, zero=1.

Decomposition:
- Package seq_alu_pkg:
  - typedef enum logic[2:0] alu_op_e (OP_ADD..OP_MUL).
  - typedef enum state_e (S_IDLE, S_EXEC, S_MUL, S_RESP).
- One natural sub-module: seq_alu_mul, the shift-add multiplier datapath.
  - Ports: start, a, b, busy, done, product.
  - Instantiated only under SEQ_ALU_MUL_EN.
- Combinational op decode stays in the top.

Test Plan:
- WIDTH=8, reset then ADD a=0x26 b=0x03 -> after 2 cycles out_valid=1, result=0x29, carry=0, zero=0, ovf=0.
- SUB a=0x03 b=0x26 -> result=0xDD, carry=1. ADD a=0x7F b=0x01 -> result=0x80, ovf=1. XOR a=b=0x5A -> result=0x00, zero=1.
- SHL a=0x81 -> result=0x02, carry=1. SHR a=0x81 -> result=0x40, carry=1.
- MUL (macro on) a=0xFF b=0xFF -> out_valid after 9 cycles, result=0x01, result_hi=0xFE, carry=1. Macro off -> result=0, zero=1 after 2 cycles.
- Backpressure: hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0, new in_valid ignored. Release -> in_ready=1 next cycle.
- Drive rst_n=0 during MUL cycle 4 -> next edge state IDLE, out_valid=0, in_ready=1. A following ADD 0x01+0x01 -> result 0x02.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared types and helpers for the sequential ALU (seq_alu and its multiplier).
package seq_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_MUL  = 2'b10,
    S_RESP = 2'b11
  } state_e;

  // Two's-complement overflow from operand and result sign bits.
  function automatic logic sign_ovf(input logic sa, input logic sb, input logic sr,
                                    input logic is_sub);
    logic ovf_v;
    if (is_sub) begin
      ovf_v = (sa != sb) && (sr != sa);
    end else begin
      ovf_v = (sa == sb) && (sr != sa);
    end
    return ovf_v;
  endfunction

endpackage

// File: rtl/seq_alu_mul.sv
// Shift-add unsigned multiplier: loads on start, retires one bit of b per cycle, LSB first.
// done/product are combinational during the last iteration so the caller can register the final product.
module seq_alu_mul
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0]   mcand_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               busy_r;

  logic [WIDTH-1:0]   addend_s;
  logic [WIDTH:0]     sum_s;
  logic [2*WIDTH-1:0] step_s;

  // One iteration: add multiplicand into the upper half when the current multiplier bit is set, then shift right.
  always_comb begin
    addend_s = {WIDTH{1'b0}};
    if (acc_r[0]) begin
      addend_s = mcand_r;
    end else begin
      addend_s = {WIDTH{1'b0}};
    end
    sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, addend_s};
    step_s = {sum_s, acc_r[WIDTH-1:1]};
  end

  // Operand load, iteration counter and partial-product register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_r <= {WIDTH{1'b0}};
      acc_r   <= {(2*WIDTH){1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      busy_r  <= 1'b0;
    end else if (start) begin
      mcand_r <= a;
      acc_r   <= {{WIDTH{1'b0}}, b};
      cnt_r   <= {CNT_W{1'b0}};
      busy_r  <= 1'b1;
    end else if (busy_r) begin
      acc_r <= step_s;
      if (cnt_r == LAST_CNT) begin
        cnt_r  <= {CNT_W{1'b0}};
        busy_r <= 1'b0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign busy    = busy_r;
  assign done    = busy_r && (cnt_r == LAST_CNT);
  assign product = step_s;

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready on operands and result; one operation in flight at a time.
// Build option SEQ_ALU_MUL_EN adds the multi-cycle MUL path; without it op 111 yields a zero result.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             zero,
  output logic             ovf
);

  state_e           state_r;
  state_e           state_nxt_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  alu_op_e          op_r;

  logic             in_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] result_r;
  logic [WIDTH-1:0] result_hi_r;
  logic             carry_r;
  logic             zero_r;
  logic             ovf_r;

  logic             handshake_s;
  logic             is_mul_s;
  logic             mul_done_s;
  logic             mul_busy_s;

  logic [WIDTH:0]   wide_s;
  logic [WIDTH-1:0] res_s;
  logic             carry_s;
  logic             ovf_s;

  assign handshake_s = in_valid & in_ready_r;

`ifdef SEQ_ALU_MUL_EN
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mul_product_s;

  assign is_mul_s = (alu_op_e'(op) == OP_MUL);

  seq_alu_mul #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (handshake_s & is_mul_s),
    .a       (a),
    .b       (b),
    .busy    (mul_busy_s),
    .done    (mul_done_s),
    .product (mul_product_s)
  );
`else
  assign is_mul_s   = 1'b0;
  assign mul_done_s = 1'b0;
  assign mul_busy_s = 1'b0;
`endif

  // Next-state decode; a MUL state with an idle multiplier falls back to IDLE rather than hanging.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (handshake_s) begin
          state_nxt_s = is_mul_s ? S_MUL : S_EXEC;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_EXEC: state_nxt_s = S_RESP;
      S_MUL: begin
        if (mul_done_s) begin
          state_nxt_s = S_RESP;
        end else if (!mul_busy_s) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_MUL;
        end
      end
      S_RESP: begin
        if (out_ready) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_RESP;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Single-cycle operations on the captured operands.
  always_comb begin
    wide_s  = {(WIDTH+1){1'b0}};
    res_s   = {WIDTH{1'b0}};
    carry_s = 1'b0;
    ovf_s   = 1'b0;
    case (op_r)
      OP_ADD: begin
        wide_s  = {1'b0, a_r} + {1'b0, b_r};
        res_s   = wide_s[WIDTH-1:0];
        carry_s = wide_s[WIDTH];
        ovf_s   = sign_ovf(a_r[WIDTH-1], b_r[WIDTH-1], wide_s[WIDTH-1], 1'b0);
      end
      OP_SUB: begin
        wide_s  = {1'b0, a_r} - {1'b0, b_r};
        res_s   = wide_s[WIDTH-1:0];
        carry_s = wide_s[WIDTH];
        ovf_s   = sign_ovf(a_r[WIDTH-1], b_r[WIDTH-1], wide_s[WIDTH-1], 1'b1);
      end
      OP_AND: res_s = a_r & b_r;
      OP_OR:  res_s = a_r | b_r;
      OP_XOR: res_s = a_r ^ b_r;
      OP_SHL: begin
        res_s   = {a_r[WIDTH-2:0], 1'b0};
        carry_s = a_r[WIDTH-1];
      end
      OP_SHR: begin
        res_s   = {1'b0, a_r[WIDTH-1:1]};
        carry_s = a_r[0];
      end
      OP_MUL:  res_s = {WIDTH{1'b0}};
      default: res_s = {WIDTH{1'b0}};
    endcase
  end

  // State register and handshake flags, registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == S_IDLE);
      out_valid_r <= (state_nxt_s == S_RESP);
    end
  end

  // Operand capture at the input handshake only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r  <= {WIDTH{1'b0}};
      b_r  <= {WIDTH{1'b0}};
      op_r <= OP_ADD;
    end else if (handshake_s) begin
      a_r  <= a;
      b_r  <= b;
      op_r <= alu_op_e'(op);
    end
  end

  // Result registers: written when the operation completes, otherwise held through RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_r    <= {WIDTH{1'b0}};
      result_hi_r <= {WIDTH{1'b0}};
      carry_r     <= 1'b0;
      zero_r      <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      case (state_r)
        S_EXEC: begin
          result_r    <= res_s;
          result_hi_r <= {WIDTH{1'b0}};
          carry_r     <= carry_s;
          zero_r      <= (res_s == {WIDTH{1'b0}});
          ovf_r       <= ovf_s;
        end
`ifdef SEQ_ALU_MUL_EN
        S_MUL: begin
          if (mul_done_s) begin
            result_r    <= mul_product_s[WIDTH-1:0];
            result_hi_r <= mul_product_s[2*WIDTH-1:WIDTH];
            carry_r     <= |mul_product_s[2*WIDTH-1:WIDTH];
            zero_r      <= (mul_product_s == {(2*WIDTH){1'b0}});
            ovf_r       <= 1'b0;
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign result_hi = result_hi_r;
  assign carry     = carry_r;
  assign zero      = zero_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=8); MUL expectations follow SEQ_ALU_MUL_EN.
module tb_seq_alu;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             carry;
  logic             zero;
  logic             ovf;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .carry     (carry),
    .zero      (zero),
    .ovf       (ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation, hold it for the handshake edge, then scramble the inputs.
  task automatic start_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    int guard = 0;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    vec_cnt++;
    if (in_ready !== 1'b1) begin
      miss_cnt++;
      $display("FAIL start_in_ready: got %b want 1", in_ready);
    end
    op = o; a = x; b = y; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; a = ~x; b = ~y; op = ~o;
  endtask

  // Count edges from the handshake edge (inclusive) until out_valid rises; capped at 40.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    vec_cnt++;
    if ({out_valid, in_ready, result_hi, result, carry, zero, ovf} !== {1'b0, 1'b1, 8'h00, 8'h00, 3'b000}) begin
      miss_cnt++;
      $display("FAIL reset: got ov=%b ir=%b hi=%h res=%h c=%b z=%b o=%b want ov=0 ir=1 all zero",
               out_valid, in_ready, result_hi, result, carry, zero, ovf);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_arith();
    logic [2:0]  t_op [4] = '{3'b000, 3'b001, 3'b000, 3'b001};
    logic [7:0]  t_a  [4] = '{8'h26, 8'h03, 8'h7F, 8'h80};
    logic [7:0]  t_b  [4] = '{8'h03, 8'h26, 8'h01, 8'h01};
    logic [18:0] t_exp[4] = '{{8'h00, 8'h29, 3'b000}, {8'h00, 8'hDD, 3'b100},
                              {8'h00, 8'h80, 3'b001}, {8'h00, 8'h7F, 3'b001}};
    int lat;
    for (int i = 0; i < 4; i++) begin
      start_op(t_op[i], t_a[i], t_b[i]);
      wait_out(lat);
      vec_cnt++;
      if (lat !== 2 || {result_hi, result, carry, zero, ovf} !== t_exp[i]) begin
        miss_cnt++;
        $display("FAIL arith[%0d]: got lat=%0d {hi,res,c,z,o}=%h want lat=2 %h", i, lat,
                 {result_hi, result, carry, zero, ovf}, t_exp[i]);
      end
      consume();
    end
  endtask

  task automatic test_logic();
    logic [2:0]  t_op [3] = '{3'b100, 3'b010, 3'b011};
    logic [7:0]  t_a  [3] = '{8'h5A, 8'hF0, 8'hF0};
    logic [7:0]  t_b  [3] = '{8'h5A, 8'h3C, 8'h0F};
    logic [18:0] t_exp[3] = '{{8'h00, 8'h00, 3'b010}, {8'h00, 8'h30, 3'b000},
                              {8'h00, 8'hFF, 3'b000}};
    int lat;
    for (int i = 0; i < 3; i++) begin
      start_op(t_op[i], t_a[i], t_b[i]);
      wait_out(lat);
      vec_cnt++;
      if (lat !== 2 || {result_hi, result, carry, zero, ovf} !== t_exp[i]) begin
        miss_cnt++;
        $display("FAIL logic[%0d]: got lat=%0d {hi,res,c,z,o}=%h want lat=2 %h", i, lat,
                 {result_hi, result, carry, zero, ovf}, t_exp[i]);
      end
      consume();
    end
  endtask

  task automatic test_shift();
    logic [2:0]  t_op [3] = '{3'b101, 3'b110, 3'b101};
    logic [7:0]  t_a  [3] = '{8'h81, 8'h81, 8'h40};
    logic [18:0] t_exp[3] = '{{8'h00, 8'h02, 3'b100}, {8'h00, 8'h40, 3'b100},
                              {8'h00, 8'h80, 3'b000}};
    int lat;
    for (int i = 0; i < 3; i++) begin
      start_op(t_op[i], t_a[i], 8'hA5);
      wait_out(lat);
      vec_cnt++;
      if (lat !== 2 || {result_hi, result, carry, zero, ovf} !== t_exp[i]) begin
        miss_cnt++;
        $display("FAIL shift[%0d]: got lat=%0d {hi,res,c,z,o}=%h want lat=2 %h", i, lat,
                 {result_hi, result, carry, zero, ovf}, t_exp[i]);
      end
      consume();
    end
  endtask

  task automatic test_mul();
    logic [7:0]  t_a  [3] = '{8'hFF, 8'h00, 8'h0F};
    logic [7:0]  t_b  [3] = '{8'hFF, 8'h37, 8'h11};
`ifdef SEQ_ALU_MUL_EN
    int          exp_lat  = 9;
    logic [18:0] t_exp[3] = '{{8'hFE, 8'h01, 3'b100}, {8'h00, 8'h00, 3'b010},
                              {8'h00, 8'hFF, 3'b000}};
`else
    int          exp_lat  = 2;
    logic [18:0] t_exp[3] = '{{8'h00, 8'h00, 3'b010}, {8'h00, 8'h00, 3'b010},
                              {8'h00, 8'h00, 3'b010}};
`endif
    int lat;
    for (int i = 0; i < 3; i++) begin
      start_op(3'b111, t_a[i], t_b[i]);
      wait_out(lat);
      vec_cnt++;
      if (lat !== exp_lat || {result_hi, result, carry, zero, ovf} !== t_exp[i]) begin
        miss_cnt++;
        $display("FAIL mul[%0d]: got lat=%0d {hi,res,c,z,o}=%h want lat=%0d %h", i, lat,
                 {result_hi, result, carry, zero, ovf}, exp_lat, t_exp[i]);
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    start_op(3'b000, 8'h10, 8'h20);
    wait_out(lat);
    vec_cnt++;
    if (lat !== 2 || result !== 8'h30) begin
      miss_cnt++;
      $display("FAIL bp_first: got lat=%0d res=%h want lat=2 res=30", lat, result);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; op = 3'b001; a = 8'(i + 1); b = 8'h77;
      tick();
      vec_cnt++;
      if ({out_valid, in_ready, result, carry, zero, ovf} !== {1'b1, 1'b0, 8'h30, 3'b000}) begin
        miss_cnt++;
        $display("FAIL bp_hold[%0d]: got ov=%b ir=%b res=%h c=%b z=%b o=%b want ov=1 ir=0 res=30 flags=000",
                 i, out_valid, in_ready, result, carry, zero, ovf);
      end
    end
    in_valid = 1'b0;
    consume();
    vec_cnt++;
    if ({out_valid, in_ready} !== 2'b01) begin
      miss_cnt++;
      $display("FAIL bp_release: got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
    end
    tick();
    tick();
    tick();
    vec_cnt++;
    if ({out_valid, in_ready} !== 2'b01) begin
      miss_cnt++;
      $display("FAIL bp_no_ghost: got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat;
`ifdef SEQ_ALU_MUL_EN
    start_op(3'b111, 8'hFF, 8'hFF);
    tick();
    tick();
    tick();
`else
    start_op(3'b000, 8'h44, 8'h11);
`endif
    rst_n = 1'b0;
    tick();
    vec_cnt++;
    if ({out_valid, in_ready, result_hi, result, carry, zero, ovf} !== {1'b0, 1'b1, 8'h00, 8'h00, 3'b000}) begin
      miss_cnt++;
      $display("FAIL mid_reset: got ov=%b ir=%b hi=%h res=%h c=%b z=%b o=%b want ov=0 ir=1 all zero",
               out_valid, in_ready, result_hi, result, carry, zero, ovf);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
    end
    vec_cnt++;
    if ({out_valid, in_ready} !== 2'b01) begin
      miss_cnt++;
      $display("FAIL mid_reset_discard: got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
    end
    start_op(3'b000, 8'h01, 8'h01);
    wait_out(lat);
    vec_cnt++;
    if (lat !== 2 || {result_hi, result, carry, zero, ovf} !== {8'h00, 8'h02, 3'b000}) begin
      miss_cnt++;
      $display("FAIL post_reset_add: got lat=%0d hi=%h res=%h c=%b z=%b o=%b want lat=2 res=02 rest 0",
               lat, result_hi, result, carry, zero, ovf);
    end
    consume();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 8'h00;
    b         = 8'h00;
    op        = 3'b000;
    test_reset();
    test_arith();
    test_logic();
    test_shift();
    test_mul();
    test_backpressure();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
